// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_mem_pkg
// Description : Memory-stage opcodes, FSM encoding and opcode classifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LBU  = 4'd2;
    localparam logic [3:0] MEM_LH   = 4'd3;
    localparam logic [3:0] MEM_LHU  = 4'd4;
    localparam logic [3:0] MEM_LW   = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && lane[0]) || (word_op && (lane != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Little-endian byte-lane steering: store byte enables and
//               replicated write data, load extraction with sign/zero extend.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be    = 4'b0000;
        wdata = 32'd0;
        case (mem_op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                be    = 4'b0001 << addr;
                wdata = {4{store_data[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            MEM_LW, MEM_SW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = 32'd0;
        case (mem_op)
            MEM_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: load_data = {24'd0, w_byte};
            MEM_LH:  load_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: load_data = {16'd0, w_half};
            MEM_LW:  load_data = rdata;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline memory stage. Runs one load/store on the dmem
//               req/ack bus with timeout and returns a writeback packet.
//               Optional alignment checking: define MEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mem_op,
    input  logic [31:0]     alu_result,
    input  logic [31:0]     store_data,
    input  logic [RD_W-1:0] rd_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [31:0]     dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_ack,
    input  logic [31:0]     dmem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_en,
    output logic            bus_err,
    output logic            misalign
);

    localparam int unsigned c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    mem_state_e         state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         lane_q, lane_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [31:0]        dmem_addr_q, dmem_addr_d;
    logic [3:0]         dmem_be_q, dmem_be_d;
    logic [31:0]        dmem_wdata_q, dmem_wdata_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
    logic               wb_en_q, wb_en_d;
    logic               bus_err_q, bus_err_d;
    logic               misalign_q, misalign_d;

    logic               w_accept;
    logic               w_fault;
    logic [3:0]         w_op;
    logic [1:0]         w_lane;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load_data;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_fault = is_misaligned(mem_op, alu_result[1:0]);
`else
    assign w_fault = 1'b0;
`endif

    // One aligner serves both directions: incoming packet while idle, captured op during access.
    assign w_op   = (state_q == ST_ACCESS) ? op_q   : mem_op;
    assign w_lane = (state_q == ST_ACCESS) ? lane_q : alu_result[1:0];

    mem_lane_align u_lane_align (
        .mem_op     (w_op),
        .addr       (w_lane),
        .store_data (store_data),
        .rdata      (dmem_rdata),
        .be         (w_be),
        .wdata      (w_wdata),
        .load_data  (w_load_data)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        out_valid_d  = out_valid_q;
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        wb_en_d      = wb_en_q;
        bus_err_d    = bus_err_q;
        misalign_d   = misalign_q;

        case (state_q)
            ST_ACCESS: begin
                if (dmem_ack) begin
                    state_d     = ST_RESP;
                    dmem_req_d  = 1'b0;
                    dmem_we_d   = 1'b0;
                    out_valid_d = 1'b1;
                    if (is_load(op_q)) begin
                        wb_data_d = w_load_data;
                        wb_rd_d   = rd_q;
                        wb_en_d   = 1'b1;
                    end else begin
                        wb_data_d = 32'd0;
                        wb_rd_d   = '0;
                        wb_en_d   = 1'b0;
                    end
                end else if (TIMEOUT != 0) begin
                    if (cnt_q == c_cnt_last) begin
                        state_d     = ST_RESP;
                        dmem_req_d  = 1'b0;
                        dmem_we_d   = 1'b0;
                        out_valid_d = 1'b1;
                        wb_data_d   = 32'd0;
                        wb_rd_d     = '0;
                        wb_en_d     = 1'b0;
                        bus_err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_cnt_w'(1);
                    end
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    wb_en_d     = 1'b0;
                    bus_err_d   = 1'b0;
                    misalign_d  = 1'b0;
                end
            end
            default: ;
        endcase

        // A new packet overrides the RESP drain when both happen together.
        if (w_accept) begin
            op_d       = mem_op;
            lane_d     = alu_result[1:0];
            rd_d       = rd_in;
            cnt_d      = '0;
            bus_err_d  = 1'b0;
            misalign_d = 1'b0;
            if (w_fault) begin
                state_d     = ST_RESP;
                out_valid_d = 1'b1;
                wb_data_d   = 32'd0;
                wb_rd_d     = '0;
                wb_en_d     = 1'b0;
                misalign_d  = 1'b1;
            end else if (is_load(mem_op) || is_store(mem_op)) begin
                state_d      = ST_ACCESS;
                dmem_req_d   = 1'b1;
                dmem_we_d    = is_store(mem_op);
                dmem_addr_d  = {alu_result[31:2], 2'b00};
                dmem_be_d    = w_be;
                dmem_wdata_d = is_store(mem_op) ? w_wdata : 32'd0;
                out_valid_d  = 1'b0;
                wb_en_d      = 1'b0;
            end else begin
                state_d     = ST_RESP;
                out_valid_d = 1'b1;
                wb_data_d   = alu_result;
                wb_rd_d     = rd_in;
                wb_en_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= MEM_NONE;
            lane_q       <= 2'b00;
            rd_q         <= '0;
            cnt_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'd0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= 32'd0;
            out_valid_q  <= 1'b0;
            wb_data_q    <= 32'd0;
            wb_rd_q      <= '0;
            wb_en_q      <= 1'b0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            out_valid_q  <= out_valid_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            wb_en_q      <= wb_en_d;
            bus_err_q    <= bus_err_d;
            misalign_q   <= misalign_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign out_valid  = out_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign wb_en      = wb_en_q;
    assign bus_err    = bus_err_q;
    assign misalign   = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
//               Alignment expectations follow MEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mem_op;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic        bus_err;
    logic        misalign;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(16), .RD_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_op     (mem_op),
        .alu_result (alu_result),
        .store_data (store_data),
        .rd_in      (rd_in),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_en      (wb_en),
        .bus_err    (bus_err),
        .misalign   (misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a packet at a falling edge; it is accepted on the next rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd);
        in_valid   = 1'b1;
        mem_op     = op;
        alu_result = a;
        store_data = sd;
        rd_in      = rd;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    // Called on the first request cycle; ack is returned on request cycle k.
    task automatic ack_after(input int k, input logic [31:0] rdata);
        for (int i = 1; i < k; i++) begin
            check("req_hold", 32'(dmem_req), 32'd1);
            @(negedge clk);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ack   = 1'b0;
    endtask

    initial begin
        int req_cycles;

        rst        = 1'b0;
        in_valid   = 1'b0;
        mem_op     = MEM_NONE;
        alu_result = 32'd0;
        store_data = 32'd0;
        rd_in      = 5'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_req",       32'(dmem_req),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_wb_en",     32'(wb_en),     32'd0);
        check("rst_addr",      dmem_addr,      32'd0);
        check("rst_wb_data",   wb_data,        32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Pass-through packet, then held in RESP by backpressure
        out_ready = 1'b0;
        issue(MEM_NONE, 32'h1234_5678, 32'd0, 5'd7);
        check("none_valid",   32'(out_valid), 32'd1);
        check("none_data",    wb_data,        32'h1234_5678);
        check("none_rd",      32'(wb_rd),     32'd7);
        check("none_en",      32'(wb_en),     32'd1);
        check("none_no_req",  32'(dmem_req),  32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_data",     wb_data,        32'h1234_5678);
            check("stall_rd",       32'(wb_rd),     32'd7);
            check("stall_valid",    32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready),  32'd0);
        end

        // Release together with a new LB: accepted in the same cycle
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        mem_op     = MEM_LB;
        alu_result = 32'h0000_0103;
        rd_in      = 5'd3;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("lb_req",   32'(dmem_req),  32'd1);
        check("lb_we",    32'(dmem_we),   32'd0);
        check("lb_addr",  dmem_addr,      32'h0000_0100);
        check("lb_be",    32'(dmem_be),   32'h8);
        check("lb_drain", 32'(out_valid), 32'd0);
        ack_after(3, 32'h80FF_0000);
        check("lb_valid", 32'(out_valid), 32'd1);
        check("lb_data",  wb_data,        32'hFFFF_FF80);
        check("lb_rd",    32'(wb_rd),     32'd3);
        check("lb_en",    32'(wb_en),     32'd1);
        check("lb_req_dn", 32'(dmem_req), 32'd0);

        issue(MEM_LBU, 32'h0000_0103, 32'd0, 5'd4);
        ack_after(1, 32'h80FF_0000);
        check("lbu_data", wb_data,    32'h0000_0080);
        check("lbu_rd",   32'(wb_rd), 32'd4);

        // Halfword store on upper lanes
        issue(MEM_SH, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9);
        check("sh_we",    32'(dmem_we),  32'd1);
        check("sh_addr",  dmem_addr,     32'h0000_0200);
        check("sh_be",    32'(dmem_be),  32'hC);
        check("sh_wdata", dmem_wdata,    32'hBEEF_BEEF);
        ack_after(1, 32'd0);
        check("sh_valid", 32'(out_valid), 32'd1);
        check("sh_en",    32'(wb_en),     32'd0);
        check("sh_rd",    32'(wb_rd),     32'd0);

        issue(MEM_SB, 32'h0000_0101, 32'h1234_56A5, 5'd1);
        check("sb_be",    32'(dmem_be), 32'h2);
        check("sb_wdata", dmem_wdata,   32'hA5A5_A5A5);
        ack_after(2, 32'd0);
        check("sb_en",    32'(wb_en),   32'd0);

        issue(MEM_LH, 32'h0000_0102, 32'd0, 5'd5);
        check("lh_be",    32'(dmem_be), 32'hC);
        ack_after(1, 32'h8001_1234);
        check("lh_data",  wb_data,      32'hFFFF_8001);

        issue(MEM_SW, 32'h0000_0300, 32'hDEAD_BEEF, 5'd2);
        check("sw_be",    32'(dmem_be), 32'hF);
        check("sw_wdata", dmem_wdata,   32'hDEAD_BEEF);
        ack_after(1, 32'd0);

        // No ack: request must stay up exactly TIMEOUT cycles
        issue(MEM_LW, 32'h0000_0400, 32'd0, 5'd6);
        req_cycles = 0;
        for (int i = 0; i < 40 && dmem_req; i++) begin
            req_cycles++;
            @(negedge clk);
        end
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_valid",      32'(out_valid),  32'd1);
        check("to_bus_err",    32'(bus_err),    32'd1);
        check("to_en",         32'(wb_en),      32'd0);
        @(negedge clk);
        check("to_drained",    32'(out_valid),  32'd0);
        check("to_err_clr",    32'(bus_err),    32'd0);

        // Reset in the middle of an access
        issue(MEM_LW, 32'h0000_0300, 32'd0, 5'd2);
        @(negedge clk);
        check("mid_req", 32'(dmem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack   = 1'b0;
        check("late_ack_valid", 32'(out_valid), 32'd0);
        check("late_ack_req",   32'(dmem_req),  32'd0);
        check("late_ack_ready", 32'(in_ready),  32'd1);

        issue(MEM_LW, 32'h0000_0102, 32'd0, 5'd8);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_flag",   32'(misalign),  32'd1);
        check("mis_valid",  32'(out_valid), 32'd1);
        check("mis_no_req", 32'(dmem_req),  32'd0);
        check("mis_en",     32'(wb_en),     32'd0);
        @(negedge clk);
        check("mis_clr",    32'(misalign),  32'd0);
`else
        check("unal_req",   32'(dmem_req), 32'd1);
        check("unal_addr",  dmem_addr,     32'h0000_0100);
        check("unal_be",    32'(dmem_be),  32'hF);
        ack_after(1, 32'hCAFE_F00D);
        check("unal_data",  wb_data,       32'hCAFE_F00D);
        check("unal_flag",  32'(misalign), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
